hci_tcdm_target_bank: RTL and testbench
=======================================

// Module: hci_tcdm_target_bank
// PURPOSE
// - Target (responder) end of the HCI core protocol: one TCDM bank as seen from a hci_interconnect mems port.
// - Accepts req/gnt requests, performs byte-masked writes and 1-cycle reads on a word array, returns r_valid/r_data/r_id.
// - Honours r_ready backpressure through a bounded response FIFO and credit counter; replaces the ideal bank model in system benches.
// PARAMETERS
// - DW                   32    data width, multiple of 8; BW fixed at 8 so be width is DW/8
// - AW                   32    byte address width of tcdm_add_i
// - IW                   8     request/response id width
// - N_WORDS              1024  bank depth in words, power of 2
// - RSP_DEPTH            2     max outstanding responses (in flight + queued), >= 1
// - FILTER_WRITE_R_VALID 1'b0  1: writes produce no response and consume no credit
// PORTS
// - clk_i            in   1      clock
// - rst_ni           in   1      synchronous reset, active low
// - clear_i          in   1      synchronous clear, same effect as reset
// - tcdm_req_i       in   1      request valid
// - tcdm_gnt_o       out  1      request granted (accepted this cycle)
// - tcdm_add_i       in   AW     byte address
// - tcdm_wen_i       in   1      1 = read, 0 = write
// - tcdm_be_i        in   DW/8   byte enables (writes only)
// - tcdm_data_i      in   DW     write data
// - tcdm_id_i        in   IW     transaction id, echoed on response
// - tcdm_r_ready_i   in   1      initiator ready for response
// - tcdm_r_valid_o   out  1      response valid
// - tcdm_r_data_o    out  DW     read data (0 for write responses)
// - tcdm_r_id_o      out  IW     echoed id
// - tcdm_r_opc_o     out  1      echoed wen of the response
// BEHAVIOUR
// - Reset/clear: tcdm_gnt_o=0 during reset cycle, r_valid=0, r_data=0, r_id=0, r_opc=0; FIFO and credits zeroed; array NOT cleared.
// - Word index = tcdm_add_i[$clog2(DW/8) +: $clog2(N_WORDS)]; low and upper address bits ignored (wraps modulo bank).
// - Credits: outstanding = inflight (0/1) + fifo_count; never exceeds RSP_DEPTH.
// - gnt = req & (outstanding < RSP_DEPTH); depends on registered state only, no r_ready->gnt path.
// - Write granted at edge t: bytes with be=1 updated at t; response (if not filtered) enters response path next cycle.
// - Read granted at edge t: array sampled at t, response data available cycle t+1 (latency 1).
// - Write at t then read same word at t+1 returns new data; write and read never share a cycle (single port).
// - Response path: in-flight register -> fall-through FIFO; r_valid in cycle t+1 when FIFO empty (no extra bubble).
// - r_valid/r_data/r_id/r_opc held stable until r_valid & r_ready; pop and push in same cycle allowed at any count.
// - Responses returned strictly in grant order.
// - Filtered write (FILTER_WRITE_R_VALID=1): no inflight flag, no credit, gnt rules unchanged.
// - req with gnt=0: no side effect; initiator holds request.
// - Reset/clear mid-operation: queued/in-flight responses dropped, already-committed writes stay in array.
// STRUCTURE
// - Package hci_tcdm_target_pkg: rsp_t struct {data, id, opc}, function word_idx().
// - Sub-module hci_tcdm_rsp_fifo: fall-through FIFO of rsp_t, DEPTH=RSP_DEPTH, push/pop/full/empty/count.
// - Top: array (behavioural, synthesis replaces with macro), inflight register, credit compare, FIFO instance.
// TESTING
// - Write 0xDEADBEEF be=4'hF to 0x40, then read 0x40 id=5 -> r_valid 1 cycle after read gnt, r_data=0xDEADBEEF, r_id=5, r_opc=1.
// - Write 0x11223344 be=4'b0101 over 0xFFFFFFFF -> read returns 0xFF22FF44.
// - r_ready=0, 3 back-to-back reads, RSP_DEPTH=2 -> gnt 1,1,0; after one r_ready pulse third read granted next cycle; order preserved.
// - Read addr 0x40 and 0x40+N_WORDS*4 -> identical data (wrap); write then read same word next cycle -> new data.
// - FILTER_WRITE_R_VALID=1, 4 writes with r_ready=0 -> all granted, no r_valid; =0 -> third write stalls.
// - Assert rst_ni=0 with 2 queued responses -> r_valid=0 next cycle, gnt immediately available after reset, array content preserved.

Source files
------------

// File: rtl/hci_tcdm_target_pkg.sv
// Shared types and helpers for the HCI TCDM target bank.
// rsp_t is the response record for the default 32-bit data / 8-bit id configuration.
package hci_tcdm_target_pkg;

  localparam int unsigned DEF_DW = 32;
  localparam int unsigned DEF_IW = 8;

  typedef struct packed {
    logic [DEF_DW-1:0] data;
    logic [DEF_IW-1:0] id;
    logic              opc;
  } rsp_t;

  // Word index of a byte address: drop the byte offset, keep idx_bits, wrap modulo bank.
  function automatic logic [63:0] word_idx(input logic [63:0] addr,
                                           input int unsigned off_bits,
                                           input int unsigned idx_bits);
    return (addr >> off_bits) & ((64'd1 << idx_bits) - 64'd1);
  endfunction

endpackage

// File: rtl/hci_tcdm_rsp_fifo.sv
// Fall-through response FIFO: an empty FIFO presents the pushed entry on the same cycle,
// and a simultaneous push/pop on an empty FIFO bypasses the storage entirely.
module hci_tcdm_rsp_fifo
  import hci_tcdm_target_pkg::*;
#(
  parameter type         data_t = rsp_t,
  parameter int unsigned DEPTH  = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  data_t            data_i,
  input  logic             pop_i,
  output data_t            data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  data_t            mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_eff;
  logic             store;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty_o  = (count_q == '0);
    full_o   = (count_q == CNT_W'(DEPTH));
    count_o  = count_q;
    data_o   = empty_o ? data_i : mem_q[rd_ptr_q];
    pop_eff  = pop_i & ~empty_o;
    store    = push_i & ~(empty_o & pop_i) & (~full_o | pop_eff);
    rd_ptr_d = pop_eff ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = store ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q + CNT_W'(store) - CNT_W'(pop_eff);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/hci_tcdm_target_bank.sv
// One TCDM bank behind an HCI mems port: byte-masked writes, 1-cycle reads, and an
// in-flight register feeding a fall-through FIFO so r_ready backpressure is bounded by credits.
module hci_tcdm_target_bank
  import hci_tcdm_target_pkg::*;
#(
  parameter int unsigned DW                   = 32,
  parameter int unsigned AW                   = 32,
  parameter int unsigned IW                   = 8,
  parameter int unsigned N_WORDS              = 1024,
  parameter int unsigned RSP_DEPTH            = 2,
  parameter bit          FILTER_WRITE_R_VALID = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            tcdm_req_i,
  output logic            tcdm_gnt_o,
  input  logic [AW-1:0]   tcdm_add_i,
  input  logic            tcdm_wen_i,
  input  logic [DW/8-1:0] tcdm_be_i,
  input  logic [DW-1:0]   tcdm_data_i,
  input  logic [IW-1:0]   tcdm_id_i,
  input  logic            tcdm_r_ready_i,
  output logic            tcdm_r_valid_o,
  output logic [DW-1:0]   tcdm_r_data_o,
  output logic [IW-1:0]   tcdm_r_id_o,
  output logic            tcdm_r_opc_o
);

  localparam int unsigned BE_W  = DW / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned IDX_W = $clog2(N_WORDS);
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic          opc;
  } bank_rsp_t;

  logic [DW-1:0]    mem_q [N_WORDS];
  logic [DW-1:0]    rd_data_q;
  logic             inflight_q, inflight_d;
  logic [IW-1:0]    inflight_id_q, inflight_id_d;
  logic             inflight_opc_q, inflight_opc_d;
  logic [IDX_W-1:0] idx;
  logic [CNT_W:0]   outstanding;
  logic             needs_rsp;
  bank_rsp_t        rsp_in;
  bank_rsp_t        rsp_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  always_comb begin
    idx         = IDX_W'(word_idx(64'(tcdm_add_i), OFF_W, IDX_W));
    outstanding = (CNT_W+1)'(inflight_q) + (CNT_W+1)'(fifo_count);
    // Credits come from registered state only, so r_ready never reaches gnt.
    tcdm_gnt_o  = tcdm_req_i & rst_ni & ~clear_i & ~fifo_full
                  & (outstanding < (CNT_W+1)'(RSP_DEPTH));
    needs_rsp   = tcdm_wen_i | ~FILTER_WRITE_R_VALID;

    inflight_d     = tcdm_gnt_o & needs_rsp;
    inflight_id_d  = tcdm_gnt_o ? tcdm_id_i  : inflight_id_q;
    inflight_opc_d = tcdm_gnt_o ? tcdm_wen_i : inflight_opc_q;

    rsp_in.data = inflight_opc_q ? rd_data_q : '0;
    rsp_in.id   = inflight_id_q;
    rsp_in.opc  = inflight_opc_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      inflight_q     <= 1'b0;
      inflight_id_q  <= '0;
      inflight_opc_q <= 1'b0;
    end else begin
      inflight_q     <= inflight_d;
      inflight_id_q  <= inflight_id_d;
      inflight_opc_q <= inflight_opc_d;
    end
  end

  // Array is deliberately left out of reset so committed writes survive reset/clear.
  always_ff @(posedge clk_i) begin
    if (tcdm_gnt_o && !tcdm_wen_i) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (tcdm_be_i[b]) mem_q[idx][b*8 +: 8] <= tcdm_data_i[b*8 +: 8];
      end
    end
    if (tcdm_gnt_o && tcdm_wen_i) rd_data_q <= mem_q[idx];
  end

  hci_tcdm_rsp_fifo #(
    .data_t (bank_rsp_t),
    .DEPTH  (RSP_DEPTH)
  ) i_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (inflight_q),
    .data_i  (rsp_in),
    .pop_i   (tcdm_r_ready_i),
    .data_o  (rsp_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    tcdm_r_valid_o = inflight_q | ~fifo_empty;
    tcdm_r_data_o  = tcdm_r_valid_o ? rsp_head.data : '0;
    tcdm_r_id_o    = tcdm_r_valid_o ? rsp_head.id   : '0;
    tcdm_r_opc_o   = tcdm_r_valid_o & rsp_head.opc;
  end

endmodule

// File: tb/tb_hci_tcdm_target_bank.sv
// Bench for hci_tcdm_target_bank: a queue/array model of the bank checks every cycle,
// directed sequences pin key values, and a second instance covers write filtering.
module tb_hci_tcdm_target_bank;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clear, req, wen, r_ready;
  logic [31:0] add, wdata;
  logic [3:0]  be;
  logic [7:0]  id;
  logic        gnt, r_valid, r_opc;
  logic [31:0] r_data;
  logic [7:0]  r_id;

  logic        f_clear, f_req, f_wen, f_rready;
  logic [31:0] f_add, f_wdata;
  logic [3:0]  f_be;
  logic [7:0]  f_id;
  logic        f_gnt, f_rvalid, f_ropc;
  logic [31:0] f_rdata;
  logic [7:0]  f_rid;

  int n_cmp = 0;
  int n_bad = 0;

  hci_tcdm_target_bank #(
    .DW(32), .AW(32), .IW(8), .N_WORDS(1024), .RSP_DEPTH(DEPTH), .FILTER_WRITE_R_VALID(1'b0)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .tcdm_req_i(req), .tcdm_gnt_o(gnt), .tcdm_add_i(add), .tcdm_wen_i(wen),
    .tcdm_be_i(be), .tcdm_data_i(wdata), .tcdm_id_i(id), .tcdm_r_ready_i(r_ready),
    .tcdm_r_valid_o(r_valid), .tcdm_r_data_o(r_data), .tcdm_r_id_o(r_id), .tcdm_r_opc_o(r_opc)
  );

  hci_tcdm_target_bank #(
    .DW(32), .AW(32), .IW(8), .N_WORDS(16), .RSP_DEPTH(DEPTH), .FILTER_WRITE_R_VALID(1'b1)
  ) u_dut_f (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(f_clear),
    .tcdm_req_i(f_req), .tcdm_gnt_o(f_gnt), .tcdm_add_i(f_add), .tcdm_wen_i(f_wen),
    .tcdm_be_i(f_be), .tcdm_data_i(f_wdata), .tcdm_id_i(f_id), .tcdm_r_ready_i(f_rready),
    .tcdm_r_valid_o(f_rvalid), .tcdm_r_data_o(f_rdata), .tcdm_r_id_o(f_rid), .tcdm_r_opc_o(f_ropc)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: every granted transaction owns one queue slot until its response is
  // accepted; a response is visible the cycle after its grant and leaves in grant order.
  typedef struct {
    logic [31:0] data;
    logic [7:0]  id;
    logic        opc;
  } exp_t;

  exp_t        q[$];
  exp_t        m_e;
  logic [31:0] mmem [1024];
  int          m_idx;
  bit          m_eg, m_ev;

  always @(negedge clk) begin
    m_ev = (q.size() != 0);
    m_eg = req && rst_n && !clear && (q.size() < DEPTH);
    chk("gnt", gnt, m_eg);
    chk("r_valid", r_valid, m_ev);
    if (m_ev) begin
      chk("r_data", r_data, q[0].data);
      chk("r_id", r_id, q[0].id);
      chk("r_opc", r_opc, q[0].opc);
    end
    if (!rst_n || clear) begin
      q.delete();
    end else begin
      if (m_ev && r_ready) void'(q.pop_front());
      if (m_eg) begin
        m_idx = int'((add >> 2) & 32'h3FF);
        m_e.id = id;
        if (wen) begin
          m_e.data = mmem[m_idx];
          m_e.opc  = 1'b1;
        end else begin
          for (int b = 0; b < 4; b++)
            if (be[b]) mmem[m_idx][b*8 +: 8] = wdata[b*8 +: 8];
          m_e.data = 32'h0;
          m_e.opc  = 1'b0;
        end
        q.push_back(m_e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold a request until granted or max_wait cycles pass; waited = cycles without grant.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, input logic [7:0] i, input int max_wait,
                      output int waited);
    logic g;
    req = 1'b1; wen = w; add = a; be = b; wdata = d; id = i;
    waited = 0;
    while (waited < max_wait) begin
      @(negedge clk);
      g = gnt;
      @(posedge clk);
      #1;
      if (g) break;
      waited++;
    end
    req = 1'b0;
  endtask

  task automatic do_xfer(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, input logic [7:0] i);
    int waited;
    xfer(w, a, b, d, i, 20, waited);
    chk("grant_wait", (waited < 20), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w;
    rst_n = 1'b0; clear = 1'b0; req = 1'b1; wen = 1'b1; add = 32'h40; be = 4'h0;
    wdata = 32'h0; id = 8'h0; r_ready = 1'b1;
    f_clear = 1'b0; f_req = 1'b0; f_wen = 1'b1; f_add = 32'h0; f_be = 4'h0;
    f_wdata = 32'h0; f_id = 8'h0; f_rready = 1'b1;

    // Reset state, with a request pending
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", r_valid, 0);
    chk("rst_rdata", r_data, 0);
    chk("rst_rid", r_id, 0);
    chk("rst_ropc", r_opc, 0);
    step(); step();
    rst_n = 1'b1; req = 1'b0;

    for (int i = 0; i < 32; i++) do_xfer(1'b0, i * 4, 4'hF, $urandom, 8'(i));

    // Write then read same word on the next cycle
    do_xfer(1'b0, 32'h40, 4'hF, 32'hDEADBEEF, 8'd1);
    do_xfer(1'b1, 32'h40, 4'h0, 32'h0, 8'd5);
    @(negedge clk);
    chk("rd_valid", r_valid, 1);
    chk("rd_data", r_data, 32'hDEADBEEF);
    chk("rd_id", r_id, 5);
    chk("rd_opc", r_opc, 1);
    step();

    // Byte-masked write
    do_xfer(1'b0, 32'h80, 4'hF, 32'hFFFFFFFF, 8'd2);
    do_xfer(1'b0, 32'h80, 4'b0101, 32'h11223344, 8'd3);
    do_xfer(1'b1, 32'h80, 4'h0, 32'h0, 8'd4);
    @(negedge clk);
    chk("be_data", r_data, 32'hFF22FF44);
    step();

    // Address wraps modulo the bank
    do_xfer(1'b1, 32'h40 + 32'd4096, 4'h0, 32'h0, 8'd6);
    @(negedge clk);
    chk("wrap_data", r_data, 32'hDEADBEEF);
    step();

    // Backpressure: third read stalls until one response is accepted
    r_ready = 1'b0;
    do_xfer(1'b1, 32'h40, 4'h0, 32'h0, 8'd1);
    do_xfer(1'b1, 32'h80, 4'h0, 32'h0, 8'd2);
    req = 1'b1; wen = 1'b1; add = 32'h0; id = 8'd3;
    @(negedge clk);
    chk("bp_gnt_a", gnt, 0);
    chk("bp_head_a", r_id, 1);
    step();
    @(negedge clk);
    chk("bp_gnt_b", gnt, 0);
    step();
    r_ready = 1'b1;
    @(negedge clk);
    chk("bp_gnt_c", gnt, 0);
    chk("bp_head_c", r_id, 1);
    step();
    r_ready = 1'b0;
    @(negedge clk);
    chk("bp_gnt_d", gnt, 1);
    chk("bp_head_d", r_id, 2);
    step();
    req = 1'b0;
    r_ready = 1'b1;
    repeat (4) step();

    // Reset with two queued responses
    r_ready = 1'b0;
    do_xfer(1'b1, 32'h40, 4'h0, 32'h0, 8'd7);
    do_xfer(1'b1, 32'h80, 4'h0, 32'h0, 8'd8);
    step();
    rst_n = 1'b0; req = 1'b1; wen = 1'b1; add = 32'h40; id = 8'd9;
    @(negedge clk);
    chk("rst2_gnt_during", gnt, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_rvalid", r_valid, 0);
    chk("rst2_gnt_after", gnt, 1);
    step();
    req = 1'b0; r_ready = 1'b1;
    @(negedge clk);
    chk("rst2_rd_valid", r_valid, 1);
    chk("rst2_rd_data", r_data, 32'hDEADBEEF);
    chk("rst2_rd_id", r_id, 9);
    step();

    // Unfiltered writes consume credits
    r_ready = 1'b0;
    xfer(1'b0, 32'h100, 4'hF, 32'h1, 8'd10, 3, w);
    chk("nf_w1", w, 0);
    xfer(1'b0, 32'h104, 4'hF, 32'h2, 8'd11, 3, w);
    chk("nf_w2", w, 0);
    xfer(1'b0, 32'h108, 4'hF, 32'h3, 8'd12, 3, w);
    chk("nf_w3_stall", w, 3);
    r_ready = 1'b1;
    repeat (3) step();

    // Randomized traffic
    repeat (300) begin
      req     = 1'($urandom_range(0, 1));
      wen     = 1'($urandom_range(0, 1));
      add     = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 31)) << 2)
                | 32'($urandom_range(0, 3));
      be      = 4'($urandom);
      wdata   = $urandom;
      id      = 8'($urandom);
      r_ready = ($urandom_range(0, 9) < 7);
      clear   = ($urandom_range(0, 99) == 0);
      step();
    end
    req = 1'b0; clear = 1'b0; r_ready = 1'b1;
    repeat (4) step();

    // Filtered writes: no response, no credit
    f_rready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      f_req = 1'b1; f_wen = 1'b0; f_add = 32'(k * 4); f_be = 4'hF;
      f_wdata = 32'hA0 + 32'(k); f_id = 8'(k);
      @(negedge clk);
      chk("flt_gnt", f_gnt, 1);
      chk("flt_rvalid", f_rvalid, 0);
      step();
    end
    f_req = 1'b0;
    @(negedge clk);
    chk("flt_idle_rvalid", f_rvalid, 0);
    step();
    f_rready = 1'b1; f_req = 1'b1; f_wen = 1'b1; f_add = 32'h8; f_id = 8'h33;
    @(negedge clk);
    chk("flt_rd_gnt", f_gnt, 1);
    step();
    f_req = 1'b0;
    @(negedge clk);
    chk("flt_rd_valid", f_rvalid, 1);
    chk("flt_rd_data", f_rdata, 32'hA2);
    chk("flt_rd_id", f_rid, 8'h33);
    chk("flt_rd_opc", f_ropc, 1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
